// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter whose state advances through per-bit JK excitation.
// It also provides terminal count, a registered wrap pulse and a saturating wrap tally.
module jk_mod_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10,
  parameter int unsigned TALLY_W = 8
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               enable,
  input  logic               up_down,
  input  logic               load,
  input  logic [WIDTH-1:0]   data,
  output logic [WIDTH-1:0]   count,
  output logic [WIDTH-1:0]   j_vec,
  output logic [WIDTH-1:0]   k_vec,
  output logic               tc,
  output logic               wrap,
  output logic [TALLY_W-1:0] wraps
);

  // One extra bit so that MODULUS == 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] jk_next;

  // Target value for the next edge; load has priority over counting.
  always_comb begin
    nxt = count;
    if (load) begin
      nxt = ({1'b0, data} < MOD_EXT) ? data : TOP;
    end else if (enable) begin
      if (up_down) begin
        nxt = (count == TOP) ? '0 : count + WIDTH'(1);
      end else begin
        nxt = (count == '0) ? TOP : count - WIDTH'(1);
      end
    end
  end

  assign j_vec = ~count & nxt;
  assign k_vec = count & ~nxt;

  assign tc = enable & ~load &
              ((up_down & (count == TOP)) | (~up_down & (count == '0)));

  // JK flip-flop behaviour per bit.
  always_comb begin
    jk_next = count;
    for (int i = 0; i < int'(WIDTH); i++) begin
      case ({j_vec[i], k_vec[i]})
        2'b10:   jk_next[i] = 1'b1;
        2'b01:   jk_next[i] = 1'b0;
        2'b11:   jk_next[i] = ~count[i];
        default: jk_next[i] = count[i];
      endcase
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      count <= '0;
      wrap  <= 1'b0;
      wraps <= '0;
    end else begin
      count <= jk_next;
      wrap  <= tc;
      if (tc && (wraps != '1)) begin
        wraps <= wraps + TALLY_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench for jk_mod_counter: driver pushes model expectations, monitor pops and checks.
module tb_jk_mod_counter;

  localparam int M = 10;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       enable = 1'b0;
  logic       up_down = 1'b0;
  logic       load = 1'b0;
  logic [3:0] data = 4'd0;

  logic [3:0] count, j_vec, k_vec;
  logic       tc, wrap;
  logic [7:0] wraps;

  logic [3:0] count_s, j_vec_s, k_vec_s;
  logic       tc_s, wrap_s;
  logic [1:0] wraps_s;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10), .TALLY_W(8)) dut (
    .clk(clk), .clear(clear), .enable(enable), .up_down(up_down), .load(load),
    .data(data), .count(count), .j_vec(j_vec), .k_vec(k_vec), .tc(tc),
    .wrap(wrap), .wraps(wraps)
  );

  jk_mod_counter #(.WIDTH(4), .MODULUS(10), .TALLY_W(2)) dut_sat (
    .clk(clk), .clear(clear), .enable(enable), .up_down(up_down), .load(load),
    .data(data), .count(count_s), .j_vec(j_vec_s), .k_vec(k_vec_s), .tc(tc_s),
    .wrap(wrap_s), .wraps(wraps_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pre_cnt;
    int pre_tc;
    int pre_j;
    int pre_k;
    int post_cnt;
    int post_wrap;
    int post_wraps;
    int post_wraps_sat;
  } exp_t;

  exp_t q[$];

  int tests = 0;
  int fails = 0;

  // Reference state: current count and total (unsaturated) number of wrap events.
  int m_cnt = 0;
  int m_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Drive one cycle of inputs at the falling edge and record what the model predicts.
  task automatic step(input bit clr, input bit en, input bit ud, input bit ld, input int d);
    exp_t e;
    int nx;
    bit t;
    @(negedge clk);
    clear = clr; enable = en; up_down = ud; load = ld; data = 4'(d);
    if (clr) begin
      m_cnt = 0;
      m_total = 0;
    end
    if (ld)          nx = (d < M) ? d : M - 1;
    else if (en)     nx = ud ? (m_cnt + 1) % M : (m_cnt + M - 1) % M;
    else             nx = m_cnt;
    t = en && !ld && ((ud && m_cnt == M - 1) || (!ud && m_cnt == 0));
    e.pre_cnt = m_cnt;
    e.pre_tc  = int'(t);
    e.pre_j   = ~m_cnt & nx & 15;
    e.pre_k   = m_cnt & ~nx & 15;
    if (clr) begin
      e.post_cnt = 0; e.post_wrap = 0; e.post_wraps = 0; e.post_wraps_sat = 0;
    end else begin
      m_cnt = nx;
      if (t) m_total++;
      e.post_cnt       = nx;
      e.post_wrap      = int'(t);
      e.post_wraps     = min_i(m_total, 255);
      e.post_wraps_sat = min_i(m_total, 3);
    end
    q.push_back(e);
  endtask

  // Monitor: combinational checks mid-low-phase, registered checks just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() == 0) continue;
      e = q.pop_front();
      chk("count_pre", int'(count), e.pre_cnt);
      chk("tc",        int'(tc),    e.pre_tc);
      chk("j_vec",     int'(j_vec), e.pre_j);
      chk("k_vec",     int'(k_vec), e.pre_k);
      @(posedge clk);
      #1;
      chk("count",     int'(count),   e.post_cnt);
      chk("wrap",      int'(wrap),    e.post_wrap);
      chk("wraps",     int'(wraps),   e.post_wraps);
      chk("wrap_sat",  int'(wrap_s),  e.post_wrap);
      chk("wraps_sat", int'(wraps_s), e.post_wraps_sat);
    end
  end

  initial begin
    // Reset, then async clear while the count sits at 7, held over several edges.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 7);
    step(0, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 5);
    step(1, 0, 0, 0, 0);
    // Up wrap over ten edges.
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    // Down wrap from 0.
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // Load clamp and load priority over a terminal count.
    step(0, 0, 0, 1, 13);
    step(0, 1, 1, 1, 2);
    step(0, 1, 1, 1, 15);
    step(0, 1, 1, 1, 9);
    step(0, 1, 1, 1, 2);
    // Excitation across 0111 -> 1000.
    step(0, 0, 1, 1, 7);
    step(0, 1, 1, 0, 0);
    // Enough wraps to saturate the narrow tally.
    step(0, 0, 1, 1, 0);
    for (int i = 0; i < 60; i++) step(0, 1, 1, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 60; i++) step(0, 1, 0, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
